mem_port2_arbiter: RTL and testbench

- Shares port 2 of the 16-bit two-port program/data memory between three requesters: 0 = CPU data load/store, 1 = IO unit, 2 = DMA/loader.
- Port 1 stays dedicated to instruction fetch.
- Arbitration is round-robin with an optional bounded lock for read-modify-write bursts.
- Writes that collide with a same-cycle port-1 write to the same address are stalled.

---
 rtl/mem_port2_arbiter_if.sv | 31 +++
 rtl/mem_port2_arbiter.sv | 103 ++++++++++
 tb/tb_mem_port2_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port2_arbiter_if.sv
// rtl/mem_port2_arbiter_if.sv - port-2 requester, port-1 snoop and memory-side signals
interface mem_port2_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [2:0]          req;
  logic [2:0]          we;
  logic [2:0]          lock;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic [2:0]          gnt;
  logic [2:0]          rvalid;
  logic [DATA_W-1:0]   rdata;
  logic [ADDR_W-1:0]   p1_addr;
  logic                p1_write;
  logic [ADDR_W-1:0]   mem_a2;
  logic [DATA_W-1:0]   mem_w2;
  logic                mem_write2;
  logic                mem_read2;
  logic [DATA_W-1:0]   mem_r2;

  modport master (
    output req, we, lock, addr, wdata, p1_addr, p1_write, mem_r2,
    input  gnt, rvalid, rdata, mem_a2, mem_w2, mem_write2, mem_read2
  );

  modport slave (
    input  req, we, lock, addr, wdata, p1_addr, p1_write, mem_r2,
    output gnt, rvalid, rdata, mem_a2, mem_w2, mem_write2, mem_read2
  );
endinterface

// File: rtl/mem_port2_arbiter.sv
// rtl/mem_port2_arbiter.sv - round-robin arbiter with bounded lock for memory port 2
module mem_port2_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 4
) (
  input logic                clk,
  input logic                reset_n,
  mem_port2_arbiter_if.slave bus
);
  typedef logic [1:0] idx_t;

  function automatic idx_t inc3(input idx_t a, input idx_t b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  idx_t        ptr;
  idx_t        owner;
  logic        own_v;
  logic [3:0]  lock_cnt;
  logic [2:0]  rvalid_q;

  logic [ADDR_W-1:0] addr_a  [3];
  logic [DATA_W-1:0] wdata_a [3];

  for (genvar g = 0; g < 3; g++) begin : g_unpack
    assign addr_a[g]  = bus.addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = bus.wdata[g*DATA_W +: DATA_W];
  end

  idx_t       win;
  logic       any_req;
  logic       owner_hit;
  logic       stall;
  logic       grant;
  logic [2:0] win_oh;
  logic [3:0] base_cnt;
  logic [4:0] cnt_next;
  logic       keep_lock;

  // A live lock owner bypasses the scan; lowest offset from ptr wins otherwise.
  always_comb begin
    win       = ptr;
    any_req   = 1'b0;
    owner_hit = own_v && bus.req[owner];
    if (owner_hit) begin
      win     = owner;
      any_req = 1'b1;
    end else begin
      for (int k = 2; k >= 0; k--) begin
        if (bus.req[inc3(ptr, 2'(k))]) begin
          win     = inc3(ptr, 2'(k));
          any_req = 1'b1;
        end
      end
    end
  end

  assign stall     = bus.we[win] && bus.p1_write && (addr_a[win] == bus.p1_addr);
  assign grant     = any_req && !stall;
  assign win_oh    = 3'b001 << win;
  // A fresh locker starts counting from zero even if a stale owner count remains.
  assign base_cnt  = owner_hit ? lock_cnt : 4'd0;
  assign cnt_next  = {1'b0, base_cnt} + 5'd1;
  assign keep_lock = bus.lock[win] && (32'(cnt_next) < LOCK_MAX);

  assign bus.gnt        = grant ? win_oh : 3'b000;
  assign bus.mem_a2     = grant ? addr_a[win] : '0;
  assign bus.mem_w2     = grant ? wdata_a[win] : '0;
  assign bus.mem_write2 = grant && bus.we[win];
  assign bus.mem_read2  = grant && !bus.we[win];
  assign bus.rvalid     = rvalid_q;
  assign bus.rdata      = bus.mem_r2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr      <= 2'd0;
      owner    <= 2'd0;
      own_v    <= 1'b0;
      lock_cnt <= 4'd0;
      rvalid_q <= 3'b000;
    end else begin
      rvalid_q <= (grant && !bus.we[win]) ? win_oh : 3'b000;
      if (grant) begin
        if (keep_lock) begin
          own_v    <= 1'b1;
          owner    <= win;
          lock_cnt <= cnt_next[3:0];
        end else begin
          own_v    <= 1'b0;
          lock_cnt <= 4'd0;
          ptr      <= inc3(win, 2'd1);
        end
      end else if (own_v && !bus.req[owner]) begin
        own_v    <= 1'b0;
        lock_cnt <= 4'd0;
      end
    end
  end
endmodule

// File: tb/tb_mem_port2_arbiter.sv
// tb/tb_mem_port2_arbiter.sv - directed bench for mem_port2_arbiter with a read-before-write memory model
module tb_mem_port2_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_port2_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_port2_arbiter #(.ADDR_W(16), .DATA_W(16), .LOCK_MAX(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [15:0] mem [0:1023];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'hA000 + 16'(i);
    bus.mem_r2 = 16'h0000;
  end

  always @(posedge clk) begin
    if (bus.mem_read2)  bus.mem_r2 <= mem[bus.mem_a2[9:0]];
    if (bus.mem_write2) mem[bus.mem_a2[9:0]] <= bus.mem_w2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l,
                       input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                       input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
    bus.req   = r;
    bus.we    = w;
    bus.lock  = l;
    bus.addr  = {a2, a1, a0};
    bus.wdata = {d2, d1, d0};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.p1_write = 1'b0;
    bus.p1_addr  = 16'h0000;
    drive(3'b000, 3'b000, 3'b111, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_gnt", 32'(bus.gnt), 32'h0);
    chk("reset_rvalid", 32'(bus.rvalid), 32'h0);
    chk("reset_strobes", {30'h0, bus.mem_write2, bus.mem_read2}, 32'h0);
    chk("reset_a2", 32'(bus.mem_a2), 32'h0);

    // round robin over three readers
    next_cycle();
    reset_n = 1'b1;
    drive(3'b111, 3'b000, 3'b000, 16'h0010, 16'h0020, 16'h0030, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    chk("rr1_gnt", 32'(bus.gnt), 32'h1);
    chk("rr1_read2", 32'(bus.mem_read2), 32'h1);
    chk("rr1_a2", 32'(bus.mem_a2), 32'h0010);
    next_cycle(); @(negedge clk);
    chk("rr2_gnt", 32'(bus.gnt), 32'h2);
    chk("rr2_rvalid", 32'(bus.rvalid), 32'h1);
    chk("rr2_rdata", 32'(bus.rdata), 32'hA010);
    next_cycle(); @(negedge clk);
    chk("rr3_gnt", 32'(bus.gnt), 32'h4);
    chk("rr3_rvalid", 32'(bus.rvalid), 32'h2);
    chk("rr3_rdata", 32'(bus.rdata), 32'hA020);
    next_cycle(); @(negedge clk);
    chk("rr4_gnt", 32'(bus.gnt), 32'h1);
    chk("rr4_rvalid", 32'(bus.rvalid), 32'h4);
    chk("rr4_rdata", 32'(bus.rdata), 32'hA030);
    next_cycle();
    drive(3'b000, 3'b000, 3'b111, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    chk("rr5_lock_no_req_gnt", 32'(bus.gnt), 32'h0);
    chk("rr5_rvalid", 32'(bus.rvalid), 32'h1);
    chk("rr5_rdata", 32'(bus.rdata), 32'hA010);

    // write then read back through port 2 (ptr = 1)
    next_cycle();
    drive(3'b010, 3'b010, 3'b000, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h1234, 16'h0);
    @(negedge clk);
    chk("wr_gnt", 32'(bus.gnt), 32'h2);
    chk("wr_write2", 32'(bus.mem_write2), 32'h1);
    chk("wr_a2", 32'(bus.mem_a2), 32'h0100);
    chk("wr_w2", 32'(bus.mem_w2), 32'h1234);
    next_cycle();
    drive(3'b001, 3'b000, 3'b000, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    chk("rb_gnt", 32'(bus.gnt), 32'h1);
    chk("rb_no_rvalid_after_write", 32'(bus.rvalid), 32'h0);
    next_cycle();
    drive(3'b000, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    chk("rb_rvalid", 32'(bus.rvalid), 32'h1);
    chk("rb_rdata", 32'(bus.rdata), 32'h1234);

    // move ptr to 0 with a single requester-2 read
    next_cycle();
    drive(3'b100, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0030, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    chk("p2_gnt", 32'(bus.gnt), 32'h4);

    // bounded lock: four grants to requester 0, then requester 1
    next_cycle();
    drive(3'b011, 3'b000, 3'b001, 16'h0010, 16'h0020, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    chk("lk1_gnt", 32'(bus.gnt), 32'h1);
    chk("lk1_rvalid", 32'(bus.rvalid), 32'h4);
    next_cycle(); @(negedge clk);
    chk("lk2_gnt", 32'(bus.gnt), 32'h1);
    next_cycle(); @(negedge clk);
    chk("lk3_gnt", 32'(bus.gnt), 32'h1);
    next_cycle(); @(negedge clk);
    chk("lk4_gnt", 32'(bus.gnt), 32'h1);
    next_cycle(); @(negedge clk);
    chk("lk5_gnt", 32'(bus.gnt), 32'h2);
    next_cycle();
    drive(3'b000, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    chk("lk6_rvalid", 32'(bus.rvalid), 32'h2);
    chk("lk6_rdata", 32'(bus.rdata), 32'hA020);

    // collision stall (ptr = 2), requester 0 must not sneak in
    next_cycle();
    bus.p1_write = 1'b1;
    bus.p1_addr  = 16'h0200;
    drive(3'b101, 3'b100, 3'b000, 16'h0200, 16'h0, 16'h0200, 16'h0, 16'h0, 16'hBEEF);
    @(negedge clk);
    chk("st1_gnt", 32'(bus.gnt), 32'h0);
    chk("st1_strobes", {30'h0, bus.mem_write2, bus.mem_read2}, 32'h0);
    chk("st1_a2", 32'(bus.mem_a2), 32'h0);
    next_cycle(); @(negedge clk);
    chk("st2_gnt", 32'(bus.gnt), 32'h0);
    next_cycle();
    bus.p1_write = 1'b0;
    @(negedge clk);
    chk("st3_gnt", 32'(bus.gnt), 32'h4);
    chk("st3_write2", 32'(bus.mem_write2), 32'h1);
    chk("st3_a2", 32'(bus.mem_a2), 32'h0200);
    chk("st3_w2", 32'(bus.mem_w2), 32'hBEEF);

    // read of the same address during a port-1 write is not stalled
    next_cycle();
    bus.p1_write = 1'b1;
    drive(3'b001, 3'b000, 3'b000, 16'h0200, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    chk("rdcol_gnt", 32'(bus.gnt), 32'h1);
    chk("rdcol_read2", 32'(bus.mem_read2), 32'h1);
    next_cycle();
    bus.p1_write = 1'b0;
    drive(3'b010, 3'b000, 3'b000, 16'h0, 16'h0020, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    chk("rdcol_rvalid", 32'(bus.rvalid), 32'h1);
    chk("rdcol_rdata", 32'(bus.rdata), 32'hBEEF);
    chk("rr_after_gnt", 32'(bus.gnt), 32'h2);

    // reset right after a read grant discards the pending rvalid
    next_cycle();
    reset_n = 1'b0;
    drive(3'b000, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    chk("rst_rvalid_now", 32'(bus.rvalid), 32'h0);
    next_cycle(); @(negedge clk);
    chk("rst_rvalid_hold", 32'(bus.rvalid), 32'h0);
    next_cycle();
    reset_n = 1'b1;
    drive(3'b101, 3'b000, 3'b000, 16'h0010, 16'h0, 16'h0030, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    chk("post_rst_gnt", 32'(bus.gnt), 32'h1);
    chk("post_rst_no_late_rvalid", 32'(bus.rvalid), 32'h0);
    next_cycle(); @(negedge clk);
    chk("post_rst_gnt2", 32'(bus.gnt), 32'h4);
    chk("post_rst_rvalid", 32'(bus.rvalid), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
